// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared constants for the pulse-config store, readback and host decoder
package cfg_pkg;

   localparam int N_CHAN    = 8;
   localparam int N_ALINE   = 16;
   localparam int ADDR_W    = 7;
   localparam int N_WORDS   = N_CHAN * N_ALINE;
   localparam int FRAME_LEN = 264;

   localparam logic [7:0]        HEADER    = 8'hA5;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_HDR   = 3'd1;
   localparam state_t S_SCAL  = 3'd2;
   localparam state_t S_FETCH = 3'd3;
   localparam state_t S_WHI   = 3'd4;
   localparam state_t S_WLO   = 3'd5;
   localparam state_t S_CSUM  = 3'd6;
   localparam state_t S_DONE  = 3'd7;

   // Frame byte index 1..6 maps to the scalar fields that follow the header.
   function automatic logic [7:0] scalar_byte(input logic [2:0]  idx,
                                              input logic [7:0]  chsel,
                                              input logic [4:0]  alsel,
                                              input logic [31:0] ps);
      logic [7:0] b;
      case (idx)
         3'd1:    b = chsel;
         3'd2:    b = {3'b000, alsel};
         3'd3:    b = ps[31:24];
         3'd4:    b = ps[23:16];
         3'd5:    b = ps[15:8];
         3'd6:    b = ps[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/byte_tx_slot.sv
// rtl/byte_tx_slot.sv - one-byte output register with valid/ready handshake
module byte_tx_slot (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       load_i,
   input  logic [7:0] data_i,
   input  logic       tx_ready_i,
   output logic [7:0] tx_data_o,
   output logic       tx_valid_o,
   output logic       accept_o
);

   logic [7:0] data_q;
   logic       valid_q;

   assign accept_o   = valid_q & tx_ready_i;
   assign tx_data_o  = data_q;
   assign tx_valid_o = valid_q;

   // A load always wins over the accept it usually coincides with.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q  <= 8'h00;
         valid_q <= 1'b0;
      end else if (load_i) begin
         data_q  <= data_i;
         valid_q <= 1'b1;
      end else if (accept_o) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/config_readback_tx.sv
// rtl/config_readback_tx.sv - serialises the stored pulse configuration into one UART frame
module config_readback_tx
   import cfg_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              dump_req_i,
   input  logic              cfg_busy_i,
   input  logic [7:0]        channel_select_i,
   input  logic [4:0]        aline_select_i,
   input  logic [31:0]       pulse_shape_i,
   output logic [ADDR_W-1:0] cfg_addr_o,
   input  logic [15:0]       cfg_data_i,
   output logic [7:0]        tx_data_o,
   output logic              tx_valid_o,
   input  logic              tx_ready_i,
   output logic              busy_o,
   output logic              done_o
);

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        lo_q, lo_d;
   logic [7:0]        csum_q, csum_d;
   logic              pending_q, pending_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              ph_q, ph_d;
   logic [7:0]        chsel_q, chsel_d;
   logic [4:0]        alsel_q, alsel_d;
   logic [31:0]       ps_q, ps_d;

   logic              load;
   logic [7:0]        load_data;
   logic              accept;
   logic [7:0]        csum_add;

   byte_tx_slot u_slot (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (load),
      .data_i     (load_data),
      .tx_ready_i (tx_ready_i),
      .tx_data_o  (tx_data_o),
      .tx_valid_o (tx_valid_o),
      .accept_o   (accept)
   );

   assign csum_add   = csum_q + tx_data_o;
   assign cfg_addr_o = addr_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;

   // Each accept loads the next byte on the same edge, so only the fetch costs idle cycles.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      lo_d      = lo_q;
      csum_d    = csum_q;
      pending_d = pending_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      ph_d      = ph_q;
      chsel_d   = chsel_q;
      alsel_d   = alsel_q;
      ps_d      = ps_q;
      load      = 1'b0;
      load_data = 8'h00;
      case (state_q)
         S_IDLE: begin
            if (dump_req_i) begin
               pending_d = 1'b1;
               busy_d    = 1'b1;
            end
            if (pending_q && !cfg_busy_i) begin
               pending_d = 1'b0;
               chsel_d   = channel_select_i;
               alsel_d   = aline_select_i;
               ps_d      = pulse_shape_i;
               csum_d    = 8'h00;
               cnt_d     = 3'd0;
               state_d   = S_HDR;
               load      = 1'b1;
               load_data = HEADER;
            end
         end
         S_HDR: begin
            if (accept) begin
               cnt_d     = 3'd1;
               state_d   = S_SCAL;
               load      = 1'b1;
               load_data = chsel_q;
            end
         end
         S_SCAL: begin
            if (accept) begin
               csum_d = csum_add;
               if (cnt_q == 3'd6) begin
                  ph_d    = 1'b0;
                  state_d = S_FETCH;
               end else begin
                  cnt_d     = cnt_q + 3'd1;
                  load      = 1'b1;
                  load_data = scalar_byte(cnt_q + 3'd1, chsel_q, alsel_q, ps_q);
               end
            end
         end
         S_FETCH: begin
            // Registered table read: address settles in phase 0, data arrives in phase 1.
            if (!ph_q) begin
               ph_d = 1'b1;
            end else begin
               ph_d      = 1'b0;
               lo_d      = cfg_data_i[7:0];
               state_d   = S_WHI;
               load      = 1'b1;
               load_data = cfg_data_i[15:8];
            end
         end
         S_WHI: begin
            if (accept) begin
               csum_d    = csum_add;
               state_d   = S_WLO;
               load      = 1'b1;
               load_data = lo_q;
            end
         end
         S_WLO: begin
            if (accept) begin
               csum_d = csum_add;
               addr_d = addr_q + 1'b1;
               if (addr_q == LAST_ADDR) begin
                  state_d   = S_CSUM;
                  load      = 1'b1;
                  load_data = csum_add;
               end else begin
                  state_d = S_FETCH;
               end
            end
         end
         S_CSUM: begin
            if (accept) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         cnt_q     <= 3'd0;
         addr_q    <= '0;
         lo_q      <= 8'h00;
         csum_q    <= 8'h00;
         pending_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ph_q      <= 1'b0;
         chsel_q   <= 8'h00;
         alsel_q   <= 5'h00;
         ps_q      <= 32'h0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         lo_q      <= lo_d;
         csum_q    <= csum_d;
         pending_q <= pending_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ph_q      <= ph_d;
         chsel_q   <= chsel_d;
         alsel_q   <= alsel_d;
         ps_q      <= ps_d;
      end
   end

endmodule
